mips_mem_sys: RTL and testbench

//  Unified memory subsystem for the MIPS core: one single-port word array shared by
//  an instruction port and a data port through a round-robin arbiter. Each access
//  is a multi-cycle req/ready transaction with configurable wait states. Supports

---
 rtl/mips_mem_sys.sv | 213 +++++++++++++++++++++
 tb/tb_mips_mem_sys.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_sys.sv
// Unified single-port memory shared by the MIPS fetch and data ports.
// Round-robin arbitration, req/ready transactions with WAIT_CYCLES extra latency.
module mips_mem_sys #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with its inputs stable and holds them until
  // it sees ready=1 for exactly one cycle; ready is never asserted without a grant.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] WAIT_L = 3'(WAIT_CYCLES);

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              port_d_q, port_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              run_q;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic              d_err_q, d_err_d;

  logic              idle, any_req, grant_d;
  logic              op_port_d, op_we, op_uns, op_fire, misalign, wr_en;
  logic [ADDR_W-1:0] op_addr;
  logic [1:0]        op_size, lane;
  logic [31:0]       op_wdata, rd_word, shifted, load_data, wr_data;
  logic [3:0]        wr_be;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic              unused_hi;

  // run_q keeps the array untouched on the first edge after reset release.
  assign idle    = (state_q == S_IDLE);
  assign any_req = (i_req || d_req) && run_q;
  assign grant_d = d_req && (!i_req || !last_d_q);

  // With zero wait states the array op happens at the accept edge, on live inputs.
  assign op_port_d = idle ? grant_d : port_d_q;
  assign op_addr   = idle ? (grant_d ? d_addr : i_addr) : addr_q;
  assign op_size   = idle ? d_size : size_q;
  assign op_we     = idle ? (grant_d && d_we) : we_q;
  assign op_uns    = idle ? d_unsigned : uns_q;
  assign op_wdata  = idle ? d_wdata : wdata_q;
  assign op_fire   = (idle && any_req && (WAIT_L == 3'd0)) ||
                     ((state_q == S_ACCESS) && (cnt_q == 3'd1));

  assign word_idx  = op_addr[DEPTH_LOG2+1:2];
  assign lane      = op_addr[1:0];
  assign rd_word   = mem[word_idx];
  assign unused_hi = ^op_addr[ADDR_W-1:DEPTH_LOG2+2];

  assign misalign = op_port_d &&
                    (((op_size == 2'd1) && lane[0]) || (op_size[1] && (lane != 2'd0)));
  assign wr_en    = op_fire && op_we && !misalign;
  assign shifted  = rd_word >> {lane, 3'b000};

  always_comb begin
    wr_be     = 4'b1111;
    wr_data   = op_wdata;
    load_data = rd_word;
    case (op_size)
      2'd0: begin
        wr_be     = 4'b0001 << lane;
        wr_data   = {4{op_wdata[7:0]}};
        load_data = {{24{~op_uns & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        wr_be     = lane[1] ? 4'b1100 : 4'b0011;
        wr_data   = {2{op_wdata[15:0]}};
        load_data = {{16{~op_uns & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wr_be     = 4'b1111;
        wr_data   = op_wdata;
        load_data = rd_word;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    port_d_d  = port_d_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    uns_d     = uns_q;
    i_rdata_d = 32'h0;
    i_ready_d = 1'b0;
    d_rdata_d = 32'h0;
    d_ready_d = 1'b0;
    d_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          port_d_d = grant_d;
          last_d_d = grant_d;
          addr_d   = op_addr;
          size_d   = d_size;
          wdata_d  = d_wdata;
          we_d     = grant_d && d_we;
          uns_d    = d_unsigned;
          cnt_d    = WAIT_L;
          state_d  = (WAIT_L == 3'd0) ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (op_fire) begin
      if (op_port_d) begin
        d_ready_d = 1'b1;
        d_err_d   = misalign;
        d_rdata_d = (misalign || op_we) ? 32'h0 : load_data;
      end else begin
        i_ready_d = 1'b1;
        i_rdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      last_d_q  <= 1'b0;
      port_d_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'd0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      run_q     <= 1'b0;
      i_rdata_q <= 32'h0;
      i_ready_q <= 1'b0;
      d_rdata_q <= 32'h0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      port_d_q  <= port_d_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      run_q     <= 1'b1;
      i_rdata_q <= i_rdata_d;
      i_ready_q <= i_ready_d;
      d_rdata_q <= d_rdata_d;
      d_ready_q <= d_ready_d;
      d_err_q   <= d_err_d;
    end
  end

  // Array contents are deliberately not reset; unwritten lanes keep their value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_mem_sys.sv
// Directed bench for mips_mem_sys: load/store vector table at W=1, plus
// arbitration, mid-access reset, and latency sequences at W=0 and W=7.
module tb_mips_mem_sys;

  logic        clk = 1'b0;
  logic        rst;
  logic        tie0 = 1'b0;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req, z_d_req, s_d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic [31:0] i_rdata, d_rdata, z_i_rdata, z_d_rdata, s_i_rdata, s_d_rdata;
  logic        i_ready, d_ready, d_err, z_i_ready, z_d_ready, z_d_err;
  logic        s_i_ready, s_d_ready, s_d_err;
  logic [1:0]  dbg_state, z_dbg_state, s_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_mem_sys #(.ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_ready(i_ready), .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err), .dbg_state(dbg_state));

  mips_mem_sys #(.ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .i_req(tie0), .i_addr(i_addr), .i_rdata(z_i_rdata),
    .i_ready(z_i_ready), .d_req(z_d_req), .d_we(d_we), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(z_d_rdata), .d_ready(z_d_ready), .d_err(z_d_err), .dbg_state(z_dbg_state));

  mips_mem_sys #(.ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(7)) dut_w7 (
    .clk(clk), .rst(rst), .i_req(tie0), .i_addr(i_addr), .i_rdata(s_i_rdata),
    .i_ready(s_i_ready), .d_req(s_d_req), .d_we(d_we), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_ready(s_d_ready), .d_err(s_d_err), .dbg_state(s_dbg_state));

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  // Drives one data-port transaction on the W=1 instance; lat = edges from raising req to ready.
  task automatic d_access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
    bit done = 0;
    bit saw_i = 0;
    d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    d_req = 1'b1;
    lat = 0; rdata = 32'h0; err = 1'b0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (i_ready) saw_i = 1;
      if (d_ready) begin
        done = 1; rdata = d_rdata; err = d_err;
      end
    end
    d_req = 1'b0;
    if (!done) lat = -1;
    @(posedge clk); #1;
    check("d_ready_one_cycle", {31'b0, d_ready}, 32'h0);
    check("i_ready_quiet_on_d", {31'b0, saw_i}, 32'h0);
  endtask

  task automatic i_access(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    bit done = 0;
    i_addr = addr; i_req = 1'b1;
    lat = 0; rdata = 32'h0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (i_ready) begin
        done = 1; rdata = i_rdata;
      end
    end
    i_req = 1'b0;
    if (!done) lat = -1;
    @(posedge clk); #1;
  endtask

  // which: 0 selects the W=0 instance, 1 the W=7 instance.
  task automatic lat_w(input int which, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    bit done = 0;
    d_we = we; d_size = 2'd2; d_unsigned = 1'b0; d_addr = addr; d_wdata = wdata;
    if (which == 0) z_d_req = 1'b1; else s_d_req = 1'b1;
    lat = 0; rdata = 32'h0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (which == 0 && z_d_ready) begin done = 1; rdata = z_d_rdata; end
      if (which != 0 && s_d_ready) begin done = 1; rdata = s_d_rdata; end
    end
    z_d_req = 1'b0; s_d_req = 1'b0;
    if (!done) lat = -1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          ev_port[4];
    int          ev_cyc[4];
    logic [31:0] ev_data[4];
    int          n_ev;
    int          both;
    int          cyc;
    int          rdy_seen;

    rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; z_d_req = 1'b0; s_d_req = 1'b0;
    d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    check("rst_ready", {30'b0, i_ready, d_ready}, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_err", {31'b0, d_err}, 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //       we    size  uns   addr      wdata         exp_rdata     err
    add_vec(1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h11223344, 1'b0);
    add_vec(1'b1, 2'd0, 1'b0, 32'h13,   32'h000000AA, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'hFFFFFFAA, 1'b0);
    add_vec(1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'h000000AA, 1'b0);
    add_vec(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hAA223344, 1'b0);
    add_vec(1'b1, 2'd1, 1'b0, 32'h12,   32'h00008001, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'hFFFF8001, 1'b0);
    add_vec(1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        32'h00000000, 1'b1);
    add_vec(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h80013344, 1'b0);
    add_vec(1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        32'h00003344, 1'b0);
    add_vec(1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        32'h00000033, 1'b0);
    add_vec(1'b1, 2'd2, 1'b0, 32'h1010, 32'hDEADBEEF, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
    add_vec(1'b1, 2'd1, 1'b0, 32'h11,   32'h0000FFFF, 32'h00000000, 1'b1);
    add_vec(1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
    add_vec(1'b1, 2'd0, 1'b0, 32'h10,   32'h0000007F, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'h0000007F, 1'b0);
    add_vec(1'b0, 2'd0, 1'b1, 32'h12,   32'h0,        32'h000000AD, 1'b0);
    add_vec(1'b0, 2'd1, 1'b0, 32'h10,   32'h0,        32'hFFFFBE7F, 1'b0);
    add_vec(1'b1, 2'd2, 1'b0, 32'h14,   32'h0BADF00D, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'd2, 1'b0, 32'h14,   32'h0,        32'h0BADF00D, 1'b0);
    add_vec(1'b1, 2'd0, 1'b0, 32'h11,   32'h00000055, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD557F, 1'b0);

    foreach (vq[k]) begin
      d_access(vq[k].we, vq[k].size, vq[k].uns, vq[k].addr, vq[k].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", k), rd, vq[k].exp_rdata);
      check($sformatf("vec%0d_err", k), {31'b0, er}, {31'b0, vq[k].exp_err});
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'd2);
    end

    // Fetch port ignores addr[1:0] and wraps high address bits
    i_access(32'h12, rd, lat);
    check("fetch_0x12", rd, 32'hDEAD557F);
    check("fetch_latency", 32'(lat), 32'd2);
    i_access(32'h1014, rd, lat);
    check("fetch_alias_0x1014", rd, 32'h0BADF00D);

    // Both ports requesting continuously from reset: D,I,D,I every W+2 cycles
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h14; i_addr = 32'h10;
    i_req = 1'b1; d_req = 1'b1;
    n_ev = 0; both = 0; cyc = 0;
    for (int k = 0; k < 4; k++) begin ev_port[k] = -1; ev_cyc[k] = -1; ev_data[k] = 32'h0; end
    while (n_ev < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (i_ready && d_ready) both++;
      if (d_ready) begin
        ev_port[n_ev] = 1; ev_cyc[n_ev] = cyc; ev_data[n_ev] = d_rdata; n_ev++;
      end else if (i_ready) begin
        ev_port[n_ev] = 0; ev_cyc[n_ev] = cyc; ev_data[n_ev] = i_rdata; n_ev++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arb_events", 32'(n_ev), 32'd4);
    check("arb_never_both", 32'(both), 32'd0);
    check("arb_order0_D", 32'(ev_port[0]), 32'd1);
    check("arb_order1_I", 32'(ev_port[1]), 32'd0);
    check("arb_order2_D", 32'(ev_port[2]), 32'd1);
    check("arb_order3_I", 32'(ev_port[3]), 32'd0);
    for (int k = 0; k < 3; k++)
      check($sformatf("arb_gap%0d", k), 32'(ev_cyc[k+1] - ev_cyc[k]), 32'd3);
    check("arb_d_data", ev_data[0], 32'h0BADF00D);
    check("arb_i_data", ev_data[1], 32'hDEAD557F);

    // Reset during ACCESS of a store: aborted, word unchanged
    d_access(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, rd, er, lat);
    d_we = 1'b1; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
    d_req = 1'b1;
    @(posedge clk); #1;
    check("abort_in_access", {30'b0, dbg_state}, 32'd1);
    rst = 1'b0; d_req = 1'b0;
    #1;
    check("abort_state_idle", {30'b0, dbg_state}, 32'd0);
    rdy_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (d_ready || i_ready) rdy_seen++;
    end
    check("abort_no_ready", 32'(rdy_seen), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("abort_word_unchanged", rd, 32'h12345678);

    // Latency at W=0 and W=7
    lat_w(0, 1'b1, 32'h1010, 32'h01020304, rd, lat);
    check("w0_store_latency", 32'(lat), 32'd1);
    lat_w(0, 1'b0, 32'h10, 32'h0, rd, lat);
    check("w0_load_latency", 32'(lat), 32'd1);
    check("w0_alias_data", rd, 32'h01020304);
    lat_w(1, 1'b1, 32'h30, 32'hA5A55A5A, rd, lat);
    check("w7_store_latency", 32'(lat), 32'd8);
    lat_w(1, 1'b0, 32'h30, 32'h0, rd, lat);
    check("w7_load_latency", 32'(lat), 32'd8);
    check("w7_load_data", rd, 32'hA5A55A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
